ifft_stage_sequencer: RTL

IFFT_STAGE_SEQUENCER -- requirements
Module: ifft_stage_sequencer

---
 rtl/ifft_stage_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ifft_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIF IFFT.
// Walks N_LOG2 stages of N/2 butterflies with a 2-cycle write-back pipe.
module ifft_stage_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int AW     = N_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr_a,
  output logic [AW-1:0]     rd_addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr_a,
  output logic [AW-1:0]     wr_addr_b,
  output logic [N_LOG2-1:0] stage
);

  localparam int JW = N_LOG2 - 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [AW-1:0] HALF_M = AW'((1 << JW) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;
  logic [N_LOG2-1:0] stage_q, stage_d;
  logic              drain_q, drain_d;

  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic [AW-1:0]     rb_q, rb_d;
  logic [JW-1:0]     tw_q, tw_d;

  logic              wr1_q, wr2_q;
  logic [AW-1:0]     wa1_q, wb1_q;
  logic [AW-1:0]     wa2_q, wb2_q;

  logic [AW-1:0]     mask;
  logic [AW-1:0]     pos;
  logic [AW-1:0]     hi;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else if (stage_q != S_LAST) begin
          stage_d = stage_q + 1'b1;
          j_d     = '0;
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state so they register in step with it.
  always_comb begin
    mask    = HALF_M >> stage_d;
    pos     = AW'(j_d) & mask;
    hi      = AW'(j_d) & ~mask;
    rd_en_d = (state_d == RUN);
    ra_d    = ra_q;
    rb_d    = rb_q;
    tw_d    = tw_q;
    if (rd_en_d) begin
      ra_d = (hi << 1) | pos;
      rb_d = ((hi << 1) | pos) | (mask + 1'b1);
      tw_d = JW'(pos << stage_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      drain_q <= 1'b0;
      rd_en_q <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
      wr1_q   <= 1'b0;
      wr2_q   <= 1'b0;
      wa1_q   <= '0;
      wb1_q   <= '0;
      wa2_q   <= '0;
      wb2_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
      rd_en_q <= rd_en_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tw_q    <= tw_d;
      wr1_q   <= rd_en_q;
      wa1_q   <= ra_q;
      wb1_q   <= rb_q;
      wr2_q   <= wr1_q;
      wa2_q   <= wa1_q;
      wb2_q   <= wb1_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_idx    = tw_q;
  assign wr_en     = wr2_q;
  assign wr_addr_a = wa2_q;
  assign wr_addr_b = wb2_q;

endmodule
